ysyx_22050710_lsu: RTL
======================

# ysyx_22050710_lsu

Load/store unit sitting directly upstream of `ysyx_22050710_data_sram`. It accepts one memory request at a time from the execute stage over a valid/ready handshake and drives the SRAM's single address port, read enable, write enable, byte mask and write data. It then takes the SRAM's one-cycle-late read data, extracts and sign- or zero-extends the addressed field, and hands the result to writeback over a second valid/ready handshake. Misaligned accesses and illegal size codes are trapped before any SRAM access.

## Interface
- `ADDR_WD`, 32, request address and SRAM address width
- `DATA_WD`, 64, data width; fixed at 64, the only supported value
- `WMASK_WD`, 8, byte-mask width; equals DATA_WD/8
- `i_clk`  in  1  the single clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_valid`  in  1  execute stage presents a request
- `o_ready`  out  1  LSU accepts a request this cycle
- `i_store`  in  1  1 = store, 0 = load
- `i_funct3`  in  3  RV64 size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- `i_addr`  in  ADDR_WD  byte address
- `i_wdata`  in  DATA_WD  store data, right-aligned
- `o_valid`  out  1  result available to writeback
- `i_ready`  in  1  writeback consumes the result
- `o_rdata`  out  DATA_WD  extended load data; 0 for stores and faults
- `o_fault`  out  1  request was misaligned or illegal; no SRAM access occurred
- `o_sram_addr`  out  ADDR_WD  to SRAM `i_addr`; equals `i_addr` with bits [2:0] cleared
- `o_sram_ren`  out  1  to SRAM `i_ren`
- `o_sram_wen`  out  1  to SRAM `i_wen`
- `o_sram_wmask`  out  WMASK_WD  to SRAM `i_wmask`
- `o_sram_wdata`  out  DATA_WD  to SRAM `i_wdata`
- `i_sram_rdata`  in  DATA_WD  from SRAM `o_rdata`; valid the cycle after `ren`

## Operation
- FSM states:
  - IDLE: `o_ready` = 1.
  - LOAD: waiting on SRAM data.
  - RESP: `o_valid` = 1, `o_ready` = 0.
- **Accept.** A request is accepted in IDLE when `i_valid` is high. All SRAM outputs are driven combinationally from the request in that same cycle, because the SRAM samples at the closing edge.
- **Alignment.** `off` = `i_addr[2:0]`. Byte size `sz` is 1, 2, 4 or 8, taken from `i_funct3[1:0]`.
- **Fault.** A request faults if `off` is not a multiple of `sz`, or if `i_funct3` is 111, or if it is a store with `i_funct3[2]` = 1.
  - On a fault: no `ren` and no `wen`; next state RESP with `o_fault` = 1 and `o_rdata` = 0.
- **Aligned load.**
  - Accept cycle: `o_sram_ren` = 1.
  - Next state LOAD. In LOAD, `i_sram_rdata` is shifted right by 8*`off`, truncated to `sz`, then sign-extended (`i_funct3[2]` = 0) or zero-extended (`i_funct3[2]` = 1).
  - The result is registered; next state RESP.
  - `funct3` and `off` are held in registers from the accept cycle.
- **Aligned store.**
  - Accept cycle: `o_sram_wen` = 1.
  - `o_sram_wmask` = ((1<<`sz`)-1) << `off`.
  - `o_sram_wdata` = `i_wdata` << 8*`off`.
  - Next state RESP with `o_rdata` = 0 and `o_fault` = 0.
- **Response.** RESP stays until `i_ready` = 1, then goes to IDLE. The result registers hold their values while stalled.
- **Idle outputs.** Outside an accepted cycle, `ren`, `wen` and `wmask` are 0, and `addr`/`wdata` are don't-care.

## Timing
- Reset values: state IDLE, `o_valid` 0, `o_fault` 0, `o_rdata` 0, `o_sram_ren` 0, `o_sram_wen` 0, `o_sram_wmask` 0.
- While `i_rst` is high, all SRAM enables are forced to 0 regardless of `i_valid`.
- Latency from the accept edge to `o_valid`:
  - load: 2 cycles
  - store: 1 cycle
  - fault: 1 cycle
- Throughput: at most one request per 2 cycles for stores and faults, one per 3 cycles for loads. RESP does not overlap with accept.
- `o_ready` depends only on state, never combinationally on `i_ready`.
- Reset asserted in LOAD or RESP: the pending result is discarded and the FSM returns to IDLE. A store already written is not undone.
- `i_valid` dropping in IDLE before acceptance: nothing happens.
- Request inputs need only be stable during the accept cycle.

## Structure
- Shared package `ysyx_22050710_pkg`:
  - funct3 encodings (LB..LWU, SB..SD)
  - LSU state encoding (IDLE/LOAD/RESP)
  - `DATA_WD` and `WMASK_WD` constants
- Sub-module `ysyx_22050710_lsu_align` (purely combinational):
  - store path: computes fault, `wmask` and shifted `wdata`
  - load path: extracts and extends
- The top module holds the FSM, the captured `funct3`/`off`, and the result registers.

## Test plan
- LB at 0x80000003, SRAM word 0x1122334455667788 → `ren` with address 0x80000000; `o_valid` 2 cycles later; `o_rdata` = 0x0000000000000055.
- LH at 0x80000006, word 0x8001xxxxxxxxxxxx → `o_rdata` = 0xFFFFFFFFFFFF8001. The same access as LHU → 0x0000000000008001.
- SW at 0x80000004 with `i_wdata` 0xDEADBEEF → `wen` = 1, `wmask` = 0xF0, `wdata` = 0xDEADBEEF00000000. `o_valid` 1 cycle later with `o_rdata` 0 and `o_fault` 0.
- LD at 0x80000004 → no `ren`/`wen`. `o_valid` 1 cycle later with `o_fault` 1. A store with `funct3` 100 also gives `o_fault` 1.
- Hold `i_ready` = 0 for 5 cycles in RESP → `o_valid` and `o_rdata` stay stable and `o_ready` stays 0. After `i_ready` rises, the FSM is in IDLE the next cycle.
- Assert `i_rst` during LOAD → outputs return to reset values immediately. A following LD after reset releases completes normally.

Source files
------------

// File: rtl/ysyx_22050710_pkg.sv
// Shared definitions for the ysyx_22050710 load/store path: funct3 codes,
// LSU state encoding and datapath widths.
package ysyx_22050710_pkg;

    localparam int DATA_WD  = 64;
    localparam int WMASK_WD = DATA_WD / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_LOAD = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational byte-lane logic: request fault/mask/store-data placement, and
// load field extraction with sign or zero extension.
module ysyx_22050710_lsu_align
    import ysyx_22050710_pkg::*;
(
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [2:0]          req_off,
    input  logic [DATA_WD-1:0]  req_wdata,
    output logic                req_fault,
    output logic [WMASK_WD-1:0] req_wmask,
    output logic [DATA_WD-1:0]  req_wdata_sh,
    input  logic [2:0]          ld_funct3,
    input  logic [2:0]          ld_off,
    input  logic [DATA_WD-1:0]  ld_rdata,
    output logic [DATA_WD-1:0]  ld_data
);

    logic                misaligned;
    logic [WMASK_WD-1:0] base_mask;
    logic [DATA_WD-1:0]  ld_sh;
    logic                ld_sext;

    always_comb begin
        misaligned = 1'b0;
        base_mask  = '0;
        case (req_funct3[1:0])
            2'd0: base_mask = 8'h01;
            2'd1: begin
                misaligned = req_off[0];
                base_mask  = 8'h03;
            end
            2'd2: begin
                misaligned = |req_off[1:0];
                base_mask  = 8'h0F;
            end
            default: begin
                misaligned = |req_off;
                base_mask  = 8'hFF;
            end
        endcase
        // Stores have no unsigned variants, so funct3[2] on a store is illegal.
        req_fault    = misaligned | (req_funct3 == F3_ILL) | (req_store & req_funct3[2]);
        req_wmask    = base_mask << req_off;
        req_wdata_sh = req_wdata << {req_off, 3'b000};
    end

    always_comb begin
        ld_sh   = ld_rdata >> {ld_off, 3'b000};
        ld_sext = ~ld_funct3[2];
        case (ld_funct3[1:0])
            2'd0:    ld_data = {{56{ld_sext & ld_sh[7]}},  ld_sh[7:0]};
            2'd1:    ld_data = {{48{ld_sext & ld_sh[15]}}, ld_sh[15:0]};
            2'd2:    ld_data = {{32{ld_sext & ld_sh[31]}}, ld_sh[31:0]};
            default: ld_data = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit in front of ysyx_22050710_data_sram: one request in flight,
// valid/ready on both sides, misaligned/illegal requests trapped before the SRAM.
module ysyx_22050710_lsu #(
    parameter int ADDR_WD  = 32,
    parameter int DATA_WD  = 64,
    parameter int WMASK_WD = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_store,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_WD-1:0]  i_addr,
    input  logic [DATA_WD-1:0]  i_wdata,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_WD-1:0]  o_rdata,
    output logic                o_fault,
    output logic [ADDR_WD-1:0]  o_sram_addr,
    output logic                o_sram_ren,
    output logic                o_sram_wen,
    output logic [WMASK_WD-1:0] o_sram_wmask,
    output logic [DATA_WD-1:0]  o_sram_wdata,
    input  logic [DATA_WD-1:0]  i_sram_rdata
);
    import ysyx_22050710_pkg::*;

    // Handshakes (both sides): a transfer happens on a rising edge where valid
    // and ready are both high; o_ready is a function of state only.

    lsu_state_e          state_q, state_d;
    logic [2:0]          f3_q;
    logic [2:0]          off_q;
    logic [DATA_WD-1:0]  rdata_q;
    logic                fault_q;

    logic                accept;
    logic                req_fault;
    logic [WMASK_WD-1:0] req_wmask;
    logic [DATA_WD-1:0]  req_wdata_sh;
    logic [DATA_WD-1:0]  ld_data;

    ysyx_22050710_lsu_align u_align (
        .req_store    (i_store),
        .req_funct3   (i_funct3),
        .req_off      (i_addr[2:0]),
        .req_wdata    (i_wdata),
        .req_fault    (req_fault),
        .req_wmask    (req_wmask),
        .req_wdata_sh (req_wdata_sh),
        .ld_funct3    (f3_q),
        .ld_off       (off_q),
        .ld_rdata     (i_sram_rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        o_ready      = (state_q == LSU_IDLE);
        o_valid      = (state_q == LSU_RESP);
        accept       = o_ready & i_valid;
        // The SRAM samples at the edge closing the accept cycle, so drive it now.
        o_sram_ren   = accept & ~req_fault & ~i_store & ~i_rst;
        o_sram_wen   = accept & ~req_fault &  i_store & ~i_rst;
        o_sram_wmask = o_sram_wen ? req_wmask : '0;
        o_sram_addr  = {i_addr[ADDR_WD-1:3], 3'b000};
        o_sram_wdata = req_wdata_sh;
        case (state_q)
            LSU_IDLE: if (i_valid) state_d = (req_fault | i_store) ? LSU_RESP : LSU_LOAD;
            LSU_LOAD: state_d = LSU_RESP;
            LSU_RESP: if (i_ready) state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= LSU_IDLE;
            f3_q    <= 3'b000;
            off_q   <= 3'b000;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q    <= i_funct3;
                off_q   <= i_addr[2:0];
                fault_q <= req_fault;
                rdata_q <= '0;
            end else if (state_q == LSU_LOAD) begin
                rdata_q <= ld_data;
            end
        end
    end

    assign o_rdata = rdata_q;
    assign o_fault = fault_q;

endmodule
